// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC-source sequencer: request kinds, mux
// selector codes, FSM states and small decode helpers.
package pc_ctrl_pkg;

  // Width of the shared wait counter (covers VEC_TIMEOUT up to 255)
  localparam int CNT_W = 8;

  // Request kinds presented by the main control unit
  localparam logic [2:0] KIND_SEQ  = 3'd0;
  localparam logic [2:0] KIND_BEQ  = 3'd1;
  localparam logic [2:0] KIND_BNE  = 3'd2;
  localparam logic [2:0] KIND_JUMP = 3'd3;
  localparam logic [2:0] KIND_JR   = 3'd4;
  localparam logic [2:0] KIND_EXC  = 3'd5;

  // PC-source multiplexer selector codes
  localparam logic [2:0] PCSRC_SEQ = 3'd0;
  localparam logic [2:0] PCSRC_BR  = 3'd1;
  localparam logic [2:0] PCSRC_J   = 3'd2;
  localparam logic [2:0] PCSRC_JR  = 3'd3;
  localparam logic [2:0] PCSRC_EXC = 3'd4;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMP       = 3'd1,
    EXC_SAVE  = 3'd2,
    EXC_FETCH = 3'd3,
    COMMIT    = 3'd4
  } state_e;

  // True for the two conditional-branch kinds that need the ALU compare
  function automatic logic kind_is_branch(input logic [2:0] kind);
    return (kind == KIND_BEQ) || (kind == KIND_BNE);
  endfunction

  // Branch resolution: BEQ is taken on zero, BNE on non-zero
  function automatic logic [2:0] branch_sel(input logic is_bne, input logic zero);
    return (zero ^ is_bne) ? PCSRC_BR : PCSRC_SEQ;
  endfunction

endpackage

// File: rtl/pc_wait_counter.sv
// Loadable 8-bit down-counter with zero flag. Shared between the branch
// compare wait and the exception-vector fetch timeout; saturates at zero.
module pc_wait_counter
  import pc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority over decrement; decrement stops at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pc_source_ctrl.sv
// PC-source sequencer for the multicycle MIPS datapath. Accepts one
// PC-update request at a time, resolves branches / exception vector
// fetches, then drives the mux selector with a one-cycle PC write.
// Every output is a flop; no input reaches an output combinationally.
module pc_source_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int CMP_LAT     = 1,
  parameter int VEC_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_kind,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic [2:0] pc_source,
  output logic       pc_write,
  output logic       epc_write,
  output logic       vec_read,
  output logic       busy,
  output logic       vec_err
);

  // Counter preload values: the counter reaches zero on the last wait cycle
  localparam logic [CNT_W-1:0] CMP_LOAD = CNT_W'(CMP_LAT - 1);
  localparam logic [CNT_W-1:0] VEC_LOAD = CNT_W'(VEC_TIMEOUT - 1);

  state_e           state;
  logic             is_bne;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  // Counter control: preload on entry to CMP / EXC_FETCH, count down inside them
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = CMP_LOAD;
    cnt_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && kind_is_branch(req_kind)) begin
          cnt_load     = 1'b1;
          cnt_load_val = CMP_LOAD;
        end
      end
      EXC_SAVE: begin
        cnt_load     = 1'b1;
        cnt_load_val = VEC_LOAD;
      end
      CMP, EXC_FETCH: begin
        cnt_dec = 1'b1;
      end
      default: begin
        cnt_dec = 1'b0;
      end
    endcase
  end

  pc_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Sequencer FSM; outputs are set on the transition into the state that owns them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      is_bne    <= 1'b0;
      pc_source <= PCSRC_SEQ;
      pc_write  <= 1'b0;
      epc_write <= 1'b0;
      vec_read  <= 1'b0;
      busy      <= 1'b0;
      vec_err   <= 1'b0;
    end else begin
      pc_write  <= 1'b0;
      epc_write <= 1'b0;
      vec_err   <= 1'b0;
      case (state)
        IDLE: begin
          vec_read <= 1'b0;
          if (req_valid) begin
            busy   <= 1'b1;
            is_bne <= (req_kind == KIND_BNE);
            case (req_kind)
              KIND_SEQ: begin
                state     <= COMMIT;
                pc_write  <= 1'b1;
                pc_source <= PCSRC_SEQ;
              end
              KIND_JUMP: begin
                state     <= COMMIT;
                pc_write  <= 1'b1;
                pc_source <= PCSRC_J;
              end
              KIND_JR: begin
                state     <= COMMIT;
                pc_write  <= 1'b1;
                pc_source <= PCSRC_JR;
              end
              KIND_BEQ, KIND_BNE: begin
                state <= CMP;
              end
              default: begin
                // KIND_EXC and the reserved codes all take the exception path
                state     <= EXC_SAVE;
                epc_write <= 1'b1;
              end
            endcase
          end
        end
        CMP: begin
          if (cnt_zero) begin
            state     <= COMMIT;
            pc_write  <= 1'b1;
            pc_source <= branch_sel(is_bne, alu_zero);
          end
        end
        EXC_SAVE: begin
          state    <= EXC_FETCH;
          vec_read <= 1'b1;
        end
        EXC_FETCH: begin
          if (mem_ready) begin
            // A vector arriving on the timeout cycle still wins
            state     <= COMMIT;
            vec_read  <= 1'b0;
            pc_write  <= 1'b1;
            pc_source <= PCSRC_EXC;
          end else if (cnt_zero) begin
            state    <= IDLE;
            vec_read <= 1'b0;
            busy     <= 1'b0;
            vec_err  <= 1'b1;
          end else begin
            vec_read <= 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          vec_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Bench for pc_source_ctrl: two instances (CMP_LAT=1 and CMP_LAT=3) share
// stimulus; expected traces come from per-request timing rules.
module tb_pc_source_ctrl;

  localparam int WIN = 12;
  localparam int VT  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_kind = 3'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic [2:0] pcs_a, pcs_b;
  logic       pcw_a, pcw_b, epc_a, epc_b, vr_a, vr_b, busy_a, busy_b, err_a, err_b;
  logic [7:0] obs_a, obs_b;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] held_sel [2];

  pc_source_ctrl #(.CMP_LAT(1), .VEC_TIMEOUT(VT)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_source(pcs_a),
    .pc_write(pcw_a), .epc_write(epc_a), .vec_read(vr_a), .busy(busy_a), .vec_err(err_a)
  );

  pc_source_ctrl #(.CMP_LAT(3), .VEC_TIMEOUT(VT)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_source(pcs_b),
    .pc_write(pcw_b), .epc_write(epc_b), .vec_read(vr_b), .busy(busy_b), .vec_err(err_b)
  );

  assign obs_a = {pcs_a, pcw_a, epc_a, vr_a, busy_a, err_a};
  assign obs_b = {pcs_b, pcw_b, epc_b, vr_b, busy_b, err_b};

  always #5 clk = ~clk;

  // One request issued at cycle 0; zs/rs give alu_zero/mem_ready per cycle.
  // Expected trace per instance is derived from the latency rules.
  task automatic score_request(input logic [2:0] kind, input logic [15:0] zs,
                               input logic [15:0] rs, input string tag);
    logic [7:0] expv [2][WIN+1];
    for (int d = 0; d < 2; d++) begin
      int lat, commit, last_busy, vr_lo, vr_hi, epc_t, err_t;
      logic [2:0] sel;
      logic taken;
      lat = (d == 0) ? 1 : 3;
      commit = -1; vr_lo = 0; vr_hi = -1; epc_t = -1; err_t = -1;
      sel = held_sel[d];
      if (kind == 3'd0 || kind == 3'd3 || kind == 3'd4) begin
        commit = 1;
        sel = (kind == 3'd0) ? 3'd0 : (kind == 3'd3) ? 3'd2 : 3'd3;
      end else if (kind == 3'd1 || kind == 3'd2) begin
        commit = lat + 1;
        taken = (kind == 3'd1) ? zs[lat] : !zs[lat];
        sel = taken ? 3'd1 : 3'd0;
      end else begin
        epc_t = 1; vr_lo = 2; vr_hi = VT + 1;
        for (int t = VT + 1; t >= 2; t--) if (rs[t]) commit = t + 1;
        if (commit > 0) begin
          vr_hi = commit - 1;
          sel = 3'd4;
        end else begin
          err_t = VT + 2;
        end
      end
      last_busy = (commit > 0) ? commit : VT + 1;
      for (int t = 1; t <= WIN; t++) begin
        expv[d][t] = {((commit > 0) && (t >= commit)) ? sel : held_sel[d],
                      t == commit, t == epc_t, (t >= vr_lo) && (t <= vr_hi),
                      t <= last_busy, t == err_t};
      end
      expv[d][0] = 8'h00;
      if (commit > 0) held_sel[d] = sel;
    end

    req_valid = 1'b1; req_kind = kind; alu_zero = zs[0]; mem_ready = rs[0];
    for (int t = 1; t <= WIN; t++) begin
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic [7:0] got;
        got = (d == 0) ? obs_a : obs_b;
        vectors++;
        if (got !== expv[d][t]) begin
          miscompares++;
          $display("FAIL %s dut=%0d cycle=%0d got pcs|pcw|epc|vr|busy|err=%b expected=%b",
                   tag, d, t, got, expv[d][t]);
        end
      end
      req_valid = 1'b0; alu_zero = zs[t]; mem_ready = rs[t];
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_a !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_a got=%b expected=%b", obs_a, 8'h00);
    end
    vectors++;
    if (obs_b !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_b got=%b expected=%b", obs_b, 8'h00);
    end
    reset = 1'b1;
    held_sel[0] = 3'd0; held_sel[1] = 3'd0;
  endtask

  task automatic test_beq();
    logic [15:0] zs;
    zs = 16'($urandom); zs[1] = 1'b1;
    score_request(3'd1, zs, 16'($urandom), "beq_zero1");
    zs = 16'($urandom); zs[1] = 1'b0;
    score_request(3'd1, zs, 16'($urandom), "beq_zero0");
  endtask

  task automatic test_bne();
    logic [15:0] zs;
    zs = 16'($urandom); zs[1] = 1'b1; zs[2] = 1'b0; zs[3] = 1'b0;
    score_request(3'd2, zs, 16'($urandom), "bne_toggle_a");
    zs = 16'($urandom); zs[1] = 1'b0; zs[2] = 1'b1; zs[3] = 1'b0;
    score_request(3'd2, zs, 16'($urandom), "bne_toggle_b");
    zs = 16'($urandom); zs[3] = 1'b1;
    score_request(3'd2, zs, 16'($urandom), "bne_zero1");
  endtask

  task automatic test_back_to_back();
    logic [7:0] expv [7];
    expv[1] = 8'b010_10010; expv[2] = 8'b010_00000; expv[3] = 8'b011_10010;
    expv[4] = 8'b011_00000; expv[5] = 8'b011_00000; expv[6] = 8'b011_00000;
    expv[0] = 8'h00;
    req_valid = 1'b1; req_kind = 3'd3; alu_zero = 1'b0; mem_ready = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (obs_a !== expv[t]) begin
        miscompares++;
        $display("FAIL b2b_a cycle=%0d got=%b expected=%b", t, obs_a, expv[t]);
      end
      vectors++;
      if (obs_b !== expv[t]) begin
        miscompares++;
        $display("FAIL b2b_b cycle=%0d got=%b expected=%b", t, obs_b, expv[t]);
      end
      if (t == 1) req_kind = 3'd4;
      if (t == 3) req_valid = 1'b0;
      mem_ready = 1'($urandom); alu_zero = 1'($urandom);
    end
    held_sel[0] = 3'd3; held_sel[1] = 3'd3;
  endtask

  task automatic test_exc();
    logic [15:0] rs;
    rs = 16'($urandom); rs[2] = 1'b0; rs[3] = 1'b0; rs[4] = 1'b1;
    score_request(3'd5, 16'($urandom), rs, "exc_wait2");
  endtask

  task automatic test_exc_timeout();
    score_request(3'd5, 16'($urandom), 16'($urandom) & ~16'h03FC, "exc_timeout");
    score_request(3'd7, 16'($urandom), 16'($urandom) & ~16'h03FC, "rsv7_timeout");
    score_request(3'd6, 16'($urandom), 16'h0200, "exc_ready_on_last");
  endtask

  task automatic test_abort();
    logic [7:0] zero8;
    zero8 = 8'h00;
    req_valid = 1'b1; req_kind = 3'd5; mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({obs_a, obs_b} !== {zero8, zero8}) begin
      miscompares++;
      $display("FAIL abort_now got a=%b b=%b expected=%b", obs_a, obs_b, zero8);
    end
    mem_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      vectors++;
      if ({obs_a, obs_b} !== {zero8, zero8}) begin
        miscompares++;
        $display("FAIL abort_hold cycle=%0d got a=%b b=%b expected=%b", t, obs_a, obs_b, zero8);
      end
    end
    reset = 1'b1; mem_ready = 1'b0;
    held_sel[0] = 3'd0; held_sel[1] = 3'd0;
    score_request(3'd0, 16'($urandom), 16'($urandom), "seq_after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [15:0] rs;
      rs = 16'($urandom);
      for (int b = 2; b <= VT + 1; b++) rs[b] = ($urandom_range(0, 5) == 0);
      score_request(3'($urandom_range(0, 7)), 16'($urandom), rs, "random");
    end
  endtask

  initial begin
    test_reset();
    score_request(3'd0, 16'($urandom), 16'($urandom), "seq");
    test_beq();
    test_bne();
    test_back_to_back();
    test_exc();
    test_exc_timeout();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_source_ctrl.md
Name: pc_source_ctrl

Overview:
Sequencer for the 5-input PC-source multiplexer in the multicycle MIPS datapath. It accepts one PC-update request per instruction from the main control unit. For conditional branches it waits for the ALU compare. For exceptions it saves EPC and fetches the handler vector. It then drives the mux selector and a single-cycle PC write enable.

Parameters:
CMP_LAT, 1, cycles from request accept until alu_zero is valid (range 1-7)
VEC_TIMEOUT, 8, maximum cycles spent waiting for mem_ready during a vector fetch (range 1-255)

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low; 0 forces reset state immediately
req_valid  in  1  PC-update request, sampled only in IDLE
req_kind  in  3  0 SEQ, 1 BEQ, 2 BNE, 3 JUMP, 4 JR, 5 EXC, 6-7 reserved
alu_zero  in  1  ALU zero flag from the branch compare
mem_ready  in  1  handler vector is present on the mux exception input
pc_source  out  3  mux selector: 0 PC+4, 1 branch target, 2 jump target, 3 register (JR), 4 exception vector
pc_write  out  1  PC load enable, one-cycle pulse
epc_write  out  1  EPC load enable, one-cycle pulse
vec_read  out  1  memory read request for the handler vector
busy  out  1  request in progress; new req_valid is ignored while high
vec_err  out  1  one-cycle pulse: vector fetch timed out

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - pc_source=0; pc_write, epc_write, vec_read, busy and vec_err all 0.
  - Reset asserted mid-operation aborts the request; no pc_write or epc_write is issued afterwards.
- All outputs are registered or decoded from registered state only. There are no combinational paths from any input to any output.
- States:
  - IDLE: busy=0. If req_valid=1, capture req_kind, set busy=1 and branch on kind:
    - SEQ: go to COMMIT, sel=0.
    - JUMP: go to COMMIT, sel=2.
    - JR: go to COMMIT, sel=3.
    - BEQ/BNE: go to CMP, counter=CMP_LAT-1.
    - EXC: go to EXC_SAVE.
    - Reserved codes 6-7: treated as EXC.
  - CMP: decrement counter each cycle. On the cycle counter==0, sample alu_zero.
    - BEQ: taken if zero=1.
    - BNE: taken if zero=0.
    - Taken selects sel=1; not taken selects sel=0. Then go to COMMIT.
  - EXC_SAVE: epc_write=1 for exactly 1 cycle, then go to EXC_FETCH with counter=VEC_TIMEOUT-1.
  - EXC_FETCH: vec_read=1 each cycle; counter decrements.
    - mem_ready=1: go to COMMIT, sel=4.
    - Otherwise, on the cycle counter==0: go to IDLE, vec_err pulses 1 cycle, no pc_write.
    - mem_ready=1 on the timeout cycle: mem_ready wins.
  - COMMIT: pc_write=1 for 1 cycle and pc_source=sel. Go to IDLE.
- pc_source is valid in the same cycle as pc_write. It holds its value between commits.
- Latency from req_valid sampled in cycle N to the pc_write cycle:
  - SEQ/JUMP/JR: N+1.
  - BEQ/BNE: N+1+CMP_LAT.
  - EXC: N+3+k, where k is the number of wait cycles in EXC_FETCH before the cycle in which mem_ready is seen.
- busy is high from the cycle after accept through the COMMIT cycle, or through the timeout cycle.
- At most one request is in flight. There is no queue; the requester holds req_valid until it sees busy rise.
- A req_valid arriving in the cycle the FSM returns to IDLE is accepted in the following cycle.
- alu_zero and mem_ready are ignored in every state other than the ones listed above.

Decomposition:
- Shared package pc_ctrl_pkg holds:
  - req_kind codes (KIND_SEQ..KIND_EXC);
  - pc_source codes (PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR, PCSRC_EXC);
  - the state encoding (IDLE, CMP, EXC_SAVE, EXC_FETCH, COMMIT).
- One sub-module, pc_wait_counter: an 8-bit loadable down-counter with a zero flag. It is shared by CMP and EXC_FETCH.

Test Plan:
- Reset: reset=0 asserted mid-EXC_FETCH -> all outputs 0 immediately, no pc_write. Release, then SEQ request -> pc_write in cycle N+1 with pc_source=0.
- BEQ with CMP_LAT=1:
  - zero=1 -> pc_write in cycle N+2, pc_source=1.
  - zero=0 -> pc_write in cycle N+2, pc_source=0.
- BNE with CMP_LAT=3, zero=0 at sample -> pc_write in cycle N+4, pc_source=1. Toggling alu_zero before the sample cycle has no effect.
- JUMP, then JR back-to-back with req_valid held high -> pc_source=2 then 3. Each pc_write is 1 cycle, and busy blocks the second request until IDLE.
- EXC with mem_ready after 2 wait cycles -> epc_write in cycle N+1, vec_read high in N+2..N+4, pc_write in N+5 with pc_source=4.
- EXC with mem_ready never asserted, VEC_TIMEOUT=8 -> vec_read high 8 cycles, vec_err pulses, no pc_write, busy drops. A reserved kind 7 follows the same path.
